// File: rtl/ph_reg3_pkg.sv
// rtl/ph_reg3_pkg.sv - shared types and constants for the parasite-to-host register-3 FIFO
package ph_reg3_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } ph_reg3_state_t;

  localparam int PH_REG3_DW = 8;
  localparam logic [7:0] PH_REG3_RST_DATA = 8'h00;

endpackage

// File: rtl/ph_reg3_store_m.sv
// rtl/ph_reg3_store_m.sv - two-entry byte storage with write select and held read mux
module ph_reg3_store_m
  import ph_reg3_pkg::*;
#(
  parameter int DW = PH_REG3_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_b0,
  input  logic          wr_b1,
  input  logic [DW-1:0] wr_data,
  input  logic          show_b0,
  input  logic          show_b1,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] byte0_q;
  logic [DW-1:0] byte1_q;
  logic [DW-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte0_q <= DW'(PH_REG3_RST_DATA);
      byte1_q <= DW'(PH_REG3_RST_DATA);
      hold_q  <= DW'(PH_REG3_RST_DATA);
    end else begin
      if (wr_b0) byte0_q <= wr_data;
      if (wr_b1) byte1_q <= wr_data;
      hold_q <= rd_data;
    end
  end

  // hold_q keeps the host-visible byte stable while neither entry is presented,
  // even though byte0 may be rewritten during a new fill
  always_comb begin
    rd_data = hold_q;
    if (show_b0)      rd_data = byte0_q;
    else if (show_b1) rd_data = byte1_q;
  end

endmodule

// File: rtl/ph_reg3_fifo_m.sv
// rtl/ph_reg3_fifo_m.sv - parasite-to-host register-3 one/two-byte FIFO with status flags
// Optional sticky overflow/underflow flags are built when PH_REG3_ERR_EN is defined.
module ph_reg3_fifo_m
  import ph_reg3_pkg::*;
#(
  parameter int DW = PH_REG3_DW
) (
  input  logic          h_phi2,
  input  logic          rst,
  input  logic          two_byte,
  input  logic          p_we,
  input  logic [DW-1:0] p_din,
  input  logic          h_re,
  output logic [DW-1:0] h_dout,
  output logic          h_data_available,
  output logic          p_full,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr
);

  ph_reg3_state_t state_q, state_d;
  logic mode_q, mode_d;
  logic wr_acc, rd_acc;
  logic wr_b0, wr_b1;

  assign h_data_available = (state_q == FULL) || (state_q == DRAINING);
  assign p_full           = (state_q == FULL) || (state_q == DRAINING);
  assign wr_acc           = p_we && !p_full;
  assign rd_acc           = h_re && h_data_available;

  always_ff @(posedge h_phi2) begin
    if (rst) begin
      state_q <= FULL;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wr_b0   = 1'b0;
    wr_b1   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (wr_acc) begin
          wr_b0   = 1'b1;
          mode_d  = two_byte;
          state_d = two_byte ? FILLING : FULL;
        end
      end
      FILLING: begin
        if (wr_acc) begin
          wr_b1   = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (rd_acc) state_d = mode_q ? DRAINING : EMPTY;
      end
      DRAINING: begin
        if (rd_acc) state_d = EMPTY;
      end
      default: state_d = FULL;
    endcase
  end

  ph_reg3_store_m #(.DW(DW)) u_store (
    .clk     (h_phi2),
    .rst     (rst),
    .wr_b0   (wr_b0),
    .wr_b1   (wr_b1),
    .wr_data (p_din),
    .show_b0 (state_q == FULL),
    .show_b1 (state_q == DRAINING),
    .rd_data (h_dout)
  );

`ifdef PH_REG3_ERR_EN
  logic overflow_q, underflow_q;

  // a new error in the same cycle as err_clr takes precedence
  always_ff @(posedge h_phi2) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (p_we && p_full)       overflow_q <= 1'b1;
      else if (err_clr)         overflow_q <= 1'b0;
      if (h_re && !h_data_available) underflow_q <= 1'b1;
      else if (err_clr)              underflow_q <= 1'b0;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ph_reg3_fifo_m.sv
// tb/tb_ph_reg3_fifo_m.sv - randomized and directed bench for ph_reg3_fifo_m against a byte-count model
module tb_ph_reg3_fifo_m;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       two_byte = 1'b0;
  logic       p_we = 1'b0;
  logic [7:0] p_din = 8'h00;
  logic       h_re = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] h_dout;
  logic       h_data_available;
  logic       p_full;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int passes = 0;

  // model: bytes of the current batch, batch size, bytes written, bytes read
  logic [7:0] m_b [2];
  int         m_need;
  int         m_wr;
  int         m_rd;
  logic [7:0] m_dout;
  logic       m_ov;
  logic       m_un;

  always #5 clk = ~clk;

  ph_reg3_fifo_m #(.DW(8)) dut (
    .h_phi2           (clk),
    .rst              (rst),
    .two_byte         (two_byte),
    .p_we             (p_we),
    .p_din            (p_din),
    .h_re             (h_re),
    .h_dout           (h_dout),
    .h_data_available (h_data_available),
    .p_full           (p_full),
    .overflow         (overflow),
    .underflow        (underflow),
    .err_clr          (err_clr)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic m_loaded();
    return (m_need != 0) && (m_wr == m_need);
  endfunction

  task automatic do_cycle(input logic r, input logic tb2, input logic we,
                          input logic [7:0] d, input logic re, input logic clr);
    logic loaded_pre;
    rst = r; two_byte = tb2; p_we = we; p_din = d; h_re = re; err_clr = clr;
    loaded_pre = m_loaded();
    if (r) begin
      m_b[0] = 8'h00; m_b[1] = 8'h00;
      m_need = 1; m_wr = 1; m_rd = 0;
      m_ov = 1'b0; m_un = 1'b0;
    end else begin
`ifdef PH_REG3_ERR_EN
      if (we && loaded_pre) m_ov = 1'b1; else if (clr) m_ov = 1'b0;
      if (re && !loaded_pre) m_un = 1'b1; else if (clr) m_un = 1'b0;
`endif
      if (we && !loaded_pre) begin
        if (m_wr == 0) m_need = tb2 ? 2 : 1;
        m_b[m_wr] = d;
        m_wr++;
      end else if (re && loaded_pre) begin
        m_rd++;
        if (m_rd == m_need) begin
          m_need = 0; m_wr = 0; m_rd = 0;
        end
      end
    end
    if (m_loaded()) m_dout = m_b[m_rd];
    @(posedge clk);
    #1;
    check("avail", {7'd0, h_data_available}, {7'd0, m_loaded()});
    check("full",  {7'd0, p_full},           {7'd0, m_loaded()});
    check("dout",  h_dout,                   m_dout);
    check("ovf",   {7'd0, overflow},         {7'd0, m_ov});
    check("unf",   {7'd0, underflow},        {7'd0, m_un});
  endtask

  initial begin
    m_dout = 8'h00;
    @(posedge clk);
    #1;
    do_cycle(1, 0, 0, 8'h00, 0, 0);
    check("rst_dout_lit", h_dout, 8'h00);
    check("rst_avail_lit", {7'd0, h_data_available}, 8'd1);
    do_cycle(0, 0, 0, 8'h00, 1, 0);
    check("dummy_read_full_lit", {7'd0, p_full}, 8'd0);

    do_cycle(0, 0, 1, 8'hA5, 0, 0);
    check("one_byte_dout_lit", h_dout, 8'hA5);
    do_cycle(0, 0, 0, 8'h00, 1, 0);

    do_cycle(0, 1, 1, 8'h12, 0, 0);
    check("filling_avail_lit", {7'd0, h_data_available}, 8'd0);
    do_cycle(0, 1, 1, 8'h34, 0, 0);
    check("two_byte_b0_lit", h_dout, 8'h12);
    do_cycle(0, 1, 0, 8'h00, 1, 0);
    check("two_byte_b1_lit", h_dout, 8'h34);
    do_cycle(0, 1, 0, 8'h00, 1, 0);

    do_cycle(0, 0, 1, 8'h77, 0, 0);
    do_cycle(0, 0, 1, 8'hFF, 0, 0);
    check("ovf_keep_b0_lit", h_dout, 8'h77);
    do_cycle(0, 0, 0, 8'h00, 0, 1);
    do_cycle(0, 0, 0, 8'h00, 1, 0);
    do_cycle(0, 0, 0, 8'h00, 1, 0);
    do_cycle(0, 0, 0, 8'h00, 0, 1);

    do_cycle(0, 1, 1, 8'h55, 0, 0);
    do_cycle(0, 0, 0, 8'h00, 0, 0);
    check("mode_change_filling_lit", {7'd0, p_full}, 8'd0);
    do_cycle(0, 0, 1, 8'h66, 0, 0);
    do_cycle(0, 0, 0, 8'h00, 1, 0);
    check("mode_change_b1_lit", h_dout, 8'h66);
    do_cycle(0, 0, 0, 8'h00, 1, 0);

    do_cycle(0, 1, 1, 8'h9C, 0, 0);
    do_cycle(0, 1, 1, 8'hC9, 0, 0);
    do_cycle(0, 1, 0, 8'h00, 1, 0);
    do_cycle(1, 1, 0, 8'h00, 1, 0);
    check("reset_mid_dout_lit", h_dout, 8'h00);

    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
               1'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ph_reg3_fifo_m.md
# ph_reg3_fifo_m

Single-clock parasite-to-host data path for Tube register 3. It buffers one byte, or two bytes when two-byte mode is selected, between the parasite write strobe and the host read strobe. It produces the host "data available" and parasite "full" flags consumed by the register-3 status logic. It sits directly upstream of the host-side register-3 read mux and downstream of the parasite write decode.

## Interface
Parameters:
- DW, 8, data width of each FIFO entry.

Ports:
- h_phi2  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- two_byte  in  1  mode select: 1 = two-byte mode, 0 = one-byte mode. Sampled only on a write accepted in EMPTY.
- p_we  in  1  parasite write strobe, one cycle per byte.
- p_din  in  DW  parasite write data, valid with p_we.
- h_re  in  1  host read strobe, one cycle per completed host read of register 3.
- h_dout  out  DW  byte presented to the host.
- h_data_available  out  1  host may read.
- p_full  out  1  parasite must not write.
- overflow  out  1  sticky error: write while p_full (see Configuration).
- underflow  out  1  sticky error: read while !h_data_available (see Configuration).
- err_clr  in  1  clears overflow and underflow.

## Operation
- Storage: two DW-bit entries, byte0 and byte1, plus a latched mode bit mode_q.
- States: EMPTY (0 bytes), FILLING (1 byte, two-byte mode only), FULL (all bytes present), DRAINING (byte0 read, byte1 pending; two-byte mode only).
- A write is accepted when p_we is 1 and p_full is 0. A read is accepted when h_re is 1 and h_data_available is 1.
- EMPTY + accepted write: byte0 <= p_din and mode_q <= two_byte. Go to FULL if two_byte is 0, otherwise FILLING.
- FILLING + accepted write: byte1 <= p_din, go to FULL.
- FULL + accepted read: go to EMPTY if mode_q is 0, otherwise DRAINING.
- DRAINING + accepted read: go to EMPTY.
- h_data_available = (state==FULL) | (state==DRAINING).
- p_full = (state==FULL) | (state==DRAINING).
- In EMPTY and FILLING no read is accepted. In FULL and DRAINING no write is accepted. An accepted read and an accepted write therefore never occur in the same cycle.
- h_dout = byte0 in FULL and byte1 in DRAINING. In all other states it holds its last value. It is driven combinationally from registered state.
- Rejected writes leave state and data untouched. Rejected reads leave state untouched.
- A two_byte change while not EMPTY has no effect until the next write accepted in EMPTY.

## Timing
- Reset (rst=1 at an edge) sets: state=FULL, mode_q=0, byte0=0x00, byte1=0x00, overflow=0, underflow=0. Out of reset the outputs are h_data_available=1, p_full=1, h_dout=0x00: one dummy byte is pending.
- Reset has priority over all other inputs, including a write or read in the same cycle.
- Write-to-available latency is 1 edge. An accepted write at edge N gives h_data_available=1 after edge N (one-byte mode), or after the second write's edge (two-byte mode).
- Read-to-ready latency is 1 edge. After the final accepted read at edge N, p_full=0 after edge N.
- Back-to-back strobes on consecutive cycles are legal on both sides.

## Configuration
- PH_REG3_ERR_EN defined: overflow is set on any p_we while p_full=1, and underflow on any h_re while h_data_available=0. Both hold until err_clr or rst. If err_clr and a new error occur in the same cycle, the error wins.
- PH_REG3_ERR_EN undefined: overflow and underflow are tied to 0 and err_clr is ignored. The data path is unaffected.

## Structure
- Package ph_reg3_pkg holds:
  - the state typedef (EMPTY, FILLING, FULL, DRAINING, 2-bit encoding);
  - the DW default;
  - the reset data constant PH_REG3_RST_DATA = 8'h00.
- Sub-module ph_reg3_store_m holds the two-entry byte storage with write-select and read-select muxing. The state machine and flags stay in the top module.

## Test plan
- Reset release: h_data_available=1, p_full=1, h_dout=0x00. One h_re gives flags 0/0 on the next cycle.
- One-byte mode: write 0xA5 → available=1 the next cycle, h_dout=0xA5. Read → p_full=0.
- Two-byte mode: write 0x12, then 0x34. After the first write available=0 and p_full=0. After the second, available=1 and h_dout=0x12. Read → h_dout=0x34 and available stays 1. Read → EMPTY.
- Overflow: in FULL, write 0xFF → byte0 unchanged, overflow=1 (with PH_REG3_ERR_EN). err_clr → overflow=0.
- Mode change mid-fill: two_byte=1, write 0x55, drop two_byte → state remains FILLING until a second write. Full two-byte drain then completes.
- Reset mid-operation: in DRAINING with h_re and rst both high → post-reset values exactly as at reset release.
